// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - programmable tick channels with staggered synchronised reset release
`timescale 1ns/1ps
module clk_rst_seq #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int RST_HOLD = 4,
    parameter int STAGGER  = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       phase_o,
    output logic [NUM_CH-1:0]       rst_n_o,
    output logic                    ready_o
);

    localparam int LAST = RST_HOLD + (NUM_CH - 1) * STAGGER - 1;
    localparam int RC_W = (LAST < 2) ? 1 : $clog2(LAST + 1);

    typedef enum logic [1:0] {S_HOLD, S_SYNC, S_COUNT, S_DONE} seq_state_t;

    seq_state_t      state, state_nxt;
    logic [1:0]      sync_ff;
    logic [RC_W-1:0] rel_cnt, rel_cnt_nxt;
    logic [RC_W-1:0] rel_pos;
    logic            rel_active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= 2'b00;
            state   <= S_HOLD;
            rel_cnt <= '0;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
            state   <= state_nxt;
            rel_cnt <= rel_cnt_nxt;
        end
    end

    // rel_pos counts release edges from the first one where the synchroniser output is high
    always_comb begin
        state_nxt   = state;
        rel_cnt_nxt = rel_cnt;
        rel_active  = 1'b0;
        rel_pos     = '0;
        case (state)
            S_HOLD: state_nxt = S_SYNC;
            S_SYNC: begin
                if (sync_ff[1]) begin
                    rel_active = 1'b1;
                    if (LAST == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt   = S_COUNT;
                        rel_cnt_nxt = RC_W'(1);
                    end
                end
            end
            S_COUNT: begin
                rel_active = 1'b1;
                rel_pos    = rel_cnt;
                if (rel_cnt == RC_W'(LAST)) begin
                    state_nxt = S_DONE;
                end else begin
                    rel_cnt_nxt = rel_cnt + RC_W'(1);
                end
            end
            default: state_nxt = S_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_n_o <= '0;
            ready_o <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rel_active && rel_pos == RC_W'(RST_HOLD - 1 + k * STAGGER)) begin
                    rst_n_o[k] <= 1'b1;
                end
            end
            if (rel_active && rel_pos == RC_W'(LAST)) begin
                ready_o <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt, cur_div, pend_div;
        logic             pend_vld, tick_r, phase_r;
        logic [DIV_W-1:0] slice;
        logic             run, wrap;

        assign slice      = div_i[k*DIV_W +: DIV_W];
        assign run        = enable && rst_n_o[k];
        assign wrap       = run && (cnt == cur_div);
        assign tick_o[k]  = tick_r;
        assign phase_o[k] = phase_r;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                cur_div  <= '0;
                pend_div <= '0;
                pend_vld <= 1'b0;
                tick_r   <= 1'b0;
                phase_r  <= 1'b0;
            end else begin
                tick_r <= wrap;
                if (run) begin
                    if (wrap) begin
                        cnt     <= '0;
                        phase_r <= ~phase_r;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                // A load on a wrap edge bypasses the pending slot so the next period uses it
                if (!rst_n_o[k]) begin
                    if (div_load[k]) cur_div <= slice;
                end else if (wrap) begin
                    if (div_load[k])   cur_div <= slice;
                    else if (pend_vld) cur_div <= pend_div;
                    pend_vld <= 1'b0;
                end else if (div_load[k]) begin
                    pend_div <= slice;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - scoreboard bench for clk_rst_seq against a behavioural model
`timescale 1ns/1ps
module tb_clk_rst_seq;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int H  = 4;
    localparam int S  = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [N*DW-1:0] div_i = '0;
    logic [N-1:0]    div_load = '0;
    logic [N-1:0]    tick_o, phase_o, rst_n_o;
    logic            ready_o;
    logic [0:0]      t1_o, p1_o, r1_o;
    logic            rd1_o;

    always #5 clock = ~clock;

    clk_rst_seq #(.NUM_CH(N), .DIV_W(DW), .RST_HOLD(H), .STAGGER(S)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .div_i(div_i),
        .div_load(div_load), .tick_o(tick_o), .phase_o(phase_o),
        .rst_n_o(rst_n_o), .ready_o(ready_o)
    );

    clk_rst_seq #(.NUM_CH(1), .DIV_W(DW), .RST_HOLD(H), .STAGGER(0)) u_one (
        .clock(clock), .reset_n(reset_n), .enable(enable), .div_i(8'd0),
        .div_load(1'b0), .tick_o(t1_o), .phase_o(p1_o),
        .rst_n_o(r1_o), .ready_o(rd1_o)
    );

    typedef struct packed {
        logic [N-1:0] tick;
        logic [N-1:0] phase;
        logic [N-1:0] rst;
        logic         ready;
        logic         t1;
        logic         p1;
        logic         r1;
        logic         rd1;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: period counted in running cycles, release edges from arithmetic
    int           edge_n;
    logic [N-1:0] m_tick, m_phase, m_rst;
    logic         m_ready, m_t1, m_p1, m_r1, m_rd1;
    int           m_run[N], m_div[N], m_pend[N];
    bit           m_pvld[N];

    int     rel_edge[N] = '{6, 8, 10, 12};
    logic [N-1:0] seen;
    bit     seen_rdy, seen_r1, seen_t1;

    function automatic void model_reset();
        edge_n = 0;
        m_tick = '0; m_phase = '0; m_rst = '0; m_ready = 1'b0;
        m_t1 = 1'b0; m_p1 = 1'b0; m_r1 = 1'b0; m_rd1 = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_run[k] = 0; m_div[k] = 0; m_pend[k] = 0; m_pvld[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge(bit en, logic [N*DW-1:0] dv, logic [N-1:0] ld);
        edge_n++;
        for (int k = 0; k < N; k++) begin
            int slice;
            bit wrap;
            slice = int'(dv[k*DW +: DW]);
            wrap  = 1'b0;
            if (en && m_rst[k]) begin
                m_run[k]++;
                if (m_run[k] == m_div[k] + 1) begin
                    wrap = 1'b1;
                    m_run[k] = 0;
                    m_phase[k] = ~m_phase[k];
                end
            end
            m_tick[k] = wrap;
            if (!m_rst[k]) begin
                if (ld[k]) m_div[k] = slice;
            end else if (wrap) begin
                if (ld[k]) m_div[k] = slice;
                else if (m_pvld[k]) m_div[k] = m_pend[k];
                m_pvld[k] = 1'b0;
            end else if (ld[k]) begin
                m_pend[k] = slice;
                m_pvld[k] = 1'b1;
            end
        end
        m_t1 = en && m_r1;
        if (m_t1) m_p1 = ~m_p1;
        for (int k = 0; k < N; k++) m_rst[k] = (edge_n >= 2 + H + k * S);
        m_ready = (edge_n >= 2 + H + (N - 1) * S);
        m_r1    = (edge_n >= 2 + H);
        m_rd1   = m_r1;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_cycle(input bit en, input logic [N*DW-1:0] dv, input logic [N-1:0] ld);
        obs_t e;
        enable   = en;
        div_i    = dv;
        div_load = ld;
        @(posedge clock);
        #1;
        if (reset_n) model_edge(en, dv, ld);
        else         model_reset();
        e = {m_tick, m_phase, m_rst, m_ready, m_t1, m_p1, m_r1, m_rd1};
        exp_q.push_back(e);
        for (int k = 0; k < N; k++) begin
            if (!seen[k] && rst_n_o[k]) begin
                seen[k] = 1'b1;
                check_int($sformatf("rst_rel_edge[%0d]", k), edge_n, rel_edge[k]);
            end
        end
        if (!seen_rdy && ready_o) begin
            seen_rdy = 1'b1;
            check_int("ready_edge", edge_n, 12);
        end
        if (!seen_r1 && r1_o[0]) begin
            seen_r1 = 1'b1;
            check_int("one_rst_edge", edge_n, 6);
            check_int("one_ready_with_rst", int'(rd1_o), 1);
        end
        if (!seen_t1 && t1_o[0]) begin
            seen_t1 = 1'b1;
            check_int("one_first_tick_edge", edge_n, 7);
        end
    endtask

    function automatic logic [N*DW-1:0] rand_div();
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 5))
                0:       v[k*DW +: DW] = 8'd0;
                1:       v[k*DW +: DW] = 8'd1;
                2:       v[k*DW +: DW] = 8'd2;
                3:       v[k*DW +: DW] = 8'd3;
                4:       v[k*DW +: DW] = 8'($urandom_range(4, 20));
                default: v[k*DW +: DW] = 8'd255;
            endcase
        end
        return v;
    endfunction

    task automatic wait_run(input logic [N*DW-1:0] dv, input int target);
        int n;
        n = 0;
        while (m_run[1] != target && n < 300) begin
            do_cycle(1'b1, dv, '0);
            n++;
        end
        check_int("wait_run_bound", int'(n < 300), 1);
    endtask

    task automatic clear_seen();
        seen = '0; seen_rdy = 1'b0; seen_r1 = 1'b0; seen_t1 = 1'b0;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            obs_t e, g;
            e = exp_q.pop_front();
            g = {tick_o, phase_o, rst_n_o, ready_o, t1_o[0], p1_o[0], r1_o[0], rd1_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t: got %h expected %h", $time, g, e);
            end
        end
    end

    initial begin
        logic [N*DW-1:0] dv0, dvx;
        model_reset();
        clear_seen();
        dv0 = {8'd9, 8'd255, 8'd3, 8'd0};
        dvx = dv0;
        dvx[DW +: DW] = 8'd1;

        repeat (3) do_cycle(1'b0, '0, '0);
        reset_n = 1'b1;
        do_cycle(1'b1, dv0, 4'hf);
        repeat (19) do_cycle(1'b1, dv0, '0);
        check_int("all_released", int'(seen), 15);
        check_int("ready_seen", int'(seen_rdy), 1);
        repeat (580) do_cycle(1'b1, dv0, '0);

        // pending load mid-period, then a load landing on the wrap edge
        wait_run(dv0, 1);
        do_cycle(1'b1, dvx, 4'b0010);
        repeat (12) do_cycle(1'b1, dv0, '0);
        do_cycle(1'b1, dv0, 4'b0010);
        repeat (10) do_cycle(1'b1, dv0, '0);
        wait_run(dv0, 3);
        do_cycle(1'b1, dvx, 4'b0010);
        repeat (10) do_cycle(1'b1, dv0, '0);

        // enable freeze at cnt=2
        do_cycle(1'b1, dv0, 4'b0010);
        repeat (10) do_cycle(1'b1, dv0, '0);
        wait_run(dv0, 2);
        repeat (10) do_cycle(1'b0, dv0, '0);
        repeat (10) do_cycle(1'b1, dv0, '0);

        repeat (800) do_cycle($urandom_range(0, 9) != 0, rand_div(),
                              N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));

        // asynchronous reset pulse mid-cycle
        do_cycle(1'b1, dv0, '0);
        #5 reset_n = 1'b0;
        #1;
        check_int("async_rst_n_o", int'(rst_n_o), 0);
        check_int("async_tick_o", int'(tick_o), 0);
        check_int("async_phase_o", int'(phase_o), 0);
        check_int("async_ready_o", int'(ready_o), 0);
        check_int("async_one", int'({t1_o, p1_o, r1_o, rd1_o}), 0);
        #2 reset_n = 1'b1;
        model_reset();
        clear_seen();
        do_cycle(1'b1, rand_div(), 4'hf);
        repeat (29) do_cycle(1'b1, rand_div(), '0);
        check_int("all_released_again", int'(seen), 15);
        check_int("one_tick_again", int'(seen_t1), 1);

        repeat (400) do_cycle($urandom_range(0, 9) != 0, rand_div(),
                              N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        check_int("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
Parametrised clock-enable and reset-sequencing block. It generalises the bench-level free-running clock into a synthesizable unit with these features:
- NUM_CH independent programmable tick channels, each a divided clock enable with a phase level.
- A staggered, synchronised reset release per channel.
- A global ready flag.

It sits between the top-level clock/reset and the AXI4 masters, slaves and monitors that need divided timebases and ordered reset release.

Parameters:
NUM_CH, 4, number of tick/reset channels (1..16)
DIV_W, 8, divisor width per channel
RST_HOLD, 4, cycles held in reset after synchroniser output rises (>=1)
STAGGER, 2, extra release delay per channel index (>=0)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run; 0 freezes all tick counters
div_i  in  NUM_CH*DIV_W  per-channel divisor, slice k = div_i[k*DIV_W +: DIV_W]; tick period = div+1 cycles
div_load  in  NUM_CH  per-channel load strobe for div_i slice
tick_o  out  NUM_CH  one-cycle pulse per channel period
phase_o  out  NUM_CH  toggles on every tick (divided square level, period 2*(div+1))
rst_n_o  out  NUM_CH  per-channel synchronised active-low reset
ready_o  out  1  1 once all rst_n_o released

Behaviour:
Reset:
- reset_n low asynchronously forces rst_n_o=0, tick_o=0, phase_o=0 and ready_o=0.
- It also clears all counters, cur_div and pending state, plus synchroniser flops and sequencer state.
- This applies at any time, including mid-sequence or mid-count.

Release synchroniser:
- 2-flop synchroniser on reset_n, so deassertion is synchronous.
- Count edges from the first rising edge after reset_n goes high (edge 1).

Sequencer FSM, states HOLD -> SYNC -> COUNT -> DONE:
- HOLD: reset_n low.
- SYNC: waiting on 2 synchroniser flops.
- COUNT: release counter runs 0..RST_HOLD+(NUM_CH-1)*STAGGER-1.
- DONE: terminal state until reset.
- rst_n_o[k] rises on edge 2+RST_HOLD+k*STAGGER.
- ready_o rises on the same edge as rst_n_o[NUM_CH-1].
- STAGGER=0: all channels release together.
- Once released, rst_n_o stays 1 until reset_n low.

Per-channel counter (cnt, DIV_W bits):
- Runs only when enable=1 and rst_n_o[k]=1. Otherwise it holds, with tick_o[k]=0 and phase_o[k] unchanged.
- When running and cnt==cur_div: cnt<=0, tick_o<=1, phase_o toggles; cur_div<=pend_div if pend_vld, then pend_vld cleared.
- Otherwise: cnt<=cnt+1, tick_o<=0.
- First tick after release/enable follows cur_div+1 running cycles. Registered, so it is visible one edge after the counting edge.
- div=0: tick every running cycle; phase toggles every cycle.
- div=max (2^DIV_W-1): period 2^DIV_W, no overflow (compare before increment).

Divisor load:
- div_load[k] while channel not released: cur_div<=slice immediately.
- div_load[k] while released: pend_div<=slice, pend_vld<=1. It applies at the next wrap, so there are no truncated periods.
- div_load coincident with a wrap edge: new slice applied directly at that wrap (bypass). pend_vld ends 0.
- Repeated div_load before a wrap: last value wins.

Other:
- enable dropping mid-period: counter holds value; resumes exactly where it stopped; tick_o forced 0 while disabled.
- Channels are fully independent; simultaneous loads on several channels are allowed.
- Latency budget: no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset release, NUM_CH=4, RST_HOLD=4, STAGGER=2: deassert reset_n -> rst_n_o[0..3] rise on edges 6, 8, 10, 12; ready_o rises on edge 12.
- Reset mid-operation: after ready_o=1, ticks running, pulse reset_n low for 3ns mid-cycle -> all outputs 0 immediately (async). Release -> sequence repeats exactly as above.
- Divisor periods: load div=0 on ch0, 3 on ch1, 255 on ch2 before release, enable=1 -> ch0 ticks every cycle, ch1 every 4, ch2 every 256. phase_o[1] period is 8 cycles.
- Pending load: ch1 running at div=3, load div=1 at cnt=1 -> current 4-cycle period completes, then 2-cycle periods. Load coincident with a wrap edge -> next period already 2 cycles.
- Enable freeze: ch1 div=3, drop enable at cnt=2 for 10 cycles -> no ticks, phase held. After re-enable, next tick after 2 cycles (cnt 2 -> 3, wrap).
- STAGGER=0, NUM_CH=1 build: rst_n_o[0] and ready_o rise together on edge 2+RST_HOLD. div=0 tick stream starts on the following edge.
